// File: rtl/mfm_sync_deserializer_pkg.sv
// Shared MFM definitions: sync mark, word/byte widths, alignment state and the
// raw-word to data-byte decode. Used by the separator, the deserializer and capture.
package mfm_sync_deserializer_pkg;

    localparam int MFM_W  = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    // 0xA1 with a missing clock bit; cannot occur in normally encoded data.
    localparam logic [MFM_W-1:0] SYNC_A1 = 16'h4489;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } mfm_state_t;

    // Data bits sit at the even positions of a raw MFM word; odd positions are clock bits.
    function automatic logic [DATA_W-1:0] mfm_decode(input logic [MFM_W-1:0] raw);
        logic [DATA_W-1:0] data;
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = raw[2*i];
        end
        return data;
    endfunction

endpackage

// File: rtl/mfm_sync_deserializer_if.sv
// Bus between the data separator / capture side and the MFM deserializer.
// Handshake: there is no back-pressure. DATA_VALID, SYNC_FOUND and MFM_ERR are
// single-cycle strobes; RAW_WORD/DATA_OUT are stable from a DATA_VALID strobe
// until the next one, so a consumer must take the word in the strobe cycle or later.
interface mfm_sync_deserializer_if;
    import mfm_sync_deserializer_pkg::*;

    logic                  ENABLE;
    logic                  SHAPED_DATA;
    logic                  DWIN;
    logic [MFM_W-1:0]      RAW_WORD;
    logic [DATA_W-1:0]     DATA_OUT;
    logic                  DATA_VALID;
    logic                  SYNC_FOUND;
    logic                  LOCKED;
    logic                  MFM_ERR;
    mfm_state_t            STATE_DBG;

    // Deserializer side.
    modport slave (
        input  ENABLE, SHAPED_DATA, DWIN,
        output RAW_WORD, DATA_OUT, DATA_VALID, SYNC_FOUND, LOCKED, MFM_ERR, STATE_DBG
    );

    // Separator / capture side.
    modport master (
        output ENABLE, SHAPED_DATA, DWIN,
        input  RAW_WORD, DATA_OUT, DATA_VALID, SYNC_FOUND, LOCKED, MFM_ERR, STATE_DBG
    );

endinterface

// File: rtl/mfm_sync_deserializer_bit_sampler.sv
// Turns separator pulses and the DWIN window into one raw MFM bit per bit cell.
// A cell ends on any DWIN toggle; a pulse in the closing cycle still belongs to it.
module mfm_sync_deserializer_bit_sampler (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic shaped_data,
    input  logic dwin,
    output logic window_end,
    output logic new_bit
);

    logic dwin_q, dwin_d;
    logic pulse_seen_q, pulse_seen_d;

    assign window_end = (dwin != dwin_q);
    assign new_bit    = pulse_seen_q | shaped_data;

    // DWIN is tracked even while disabled so re-enabling cannot fake a cell boundary.
    always_comb begin
        dwin_d       = dwin;
        pulse_seen_d = pulse_seen_q;
        if (!enable || window_end) begin
            pulse_seen_d = 1'b0;
        end else if (shaped_data) begin
            pulse_seen_d = 1'b1;
        end
    end

    // Window edge and pulse-latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwin_q       <= 1'b0;
            pulse_seen_q <= 1'b0;
        end else begin
            dwin_q       <= dwin_d;
            pulse_seen_q <= pulse_seen_d;
        end
    end

endmodule

// File: rtl/mfm_sync_deserializer.sv
// MFM sync-hunting deserializer: shifts raw bits, locks on SYNC_WORD and emits
// aligned 16-bit raw words with their decoded data byte.
// Optional build macro MFM_ERRCHK_EN: flags coding violations while locked and
// drops lock after three violations without an intervening sync mark.
module mfm_sync_deserializer
    import mfm_sync_deserializer_pkg::*;
#(
    parameter logic [MFM_W-1:0] SYNC_WORD = SYNC_A1
) (
    input  logic                       MASTER_CLK,
    input  logic                       RESET,
    mfm_sync_deserializer_if.slave     bus
);

    logic window_end;
    logic new_bit;

    mfm_sync_deserializer_bit_sampler u_sampler (
        .clk         (MASTER_CLK),
        .rst         (RESET),
        .enable      (bus.ENABLE),
        .shaped_data (bus.SHAPED_DATA),
        .dwin        (bus.DWIN),
        .window_end  (window_end),
        .new_bit     (new_bit)
    );

    mfm_state_t         state_q, state_d;
    logic [MFM_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MFM_W-1:0]   raw_word_q, raw_word_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               sync_found_q, sync_found_d;
    logic [MFM_W-1:0]   shift_next;
    logic               sync_match;

`ifdef MFM_ERRCHK_EN
    logic               mfm_err_q, mfm_err_d;
    logic [1:0]         err_cnt_q, err_cnt_d;
    logic               code_err;
    // Adjacent ones, or a fourth zero in a row, cannot appear in valid MFM.
    assign code_err = (shift_next[1:0] == 2'b11) || (shift_next[3:0] == 4'b0000);
`endif

    // Sync is judged on the value the shift register is about to take.
    assign shift_next = {shift_q[MFM_W-2:0], new_bit};
    assign sync_match = (shift_next == SYNC_WORD);

    // Alignment FSM, word assembly and strobe generation.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        raw_word_d   = raw_word_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_found_d = 1'b0;
`ifdef MFM_ERRCHK_EN
        mfm_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
`endif
        if (!bus.ENABLE) begin
            state_d   = ST_HUNT;
            bit_cnt_d = '0;
`ifdef MFM_ERRCHK_EN
            err_cnt_d = '0;
`endif
        end else if (window_end) begin
            shift_d      = shift_next;
            sync_found_d = sync_match;
            case (state_q)
                ST_HUNT: begin
                    if (sync_match) begin
                        state_d   = ST_LOCKED;
                        bit_cnt_d = '0;
`ifdef MFM_ERRCHK_EN
                        err_cnt_d = '0;
`endif
                    end
                end
                ST_LOCKED: begin
                    // A sync mark re-aligns and wins over a word that ends on the same bit.
                    if (sync_match) begin
                        bit_cnt_d = '0;
`ifdef MFM_ERRCHK_EN
                        err_cnt_d = '0;
`endif
                    end else if (bit_cnt_q == CNT_W'(MFM_W - 1)) begin
                        raw_word_d   = shift_next;
                        data_out_d   = mfm_decode(shift_next);
                        data_valid_d = 1'b1;
                        bit_cnt_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
`ifdef MFM_ERRCHK_EN
                    if (!sync_match && code_err) begin
                        mfm_err_d = 1'b1;
                        if (err_cnt_q == 2'd2) begin
                            // Lock is lost: discard whatever word was finishing.
                            state_d      = ST_HUNT;
                            bit_cnt_d    = '0;
                            err_cnt_d    = '0;
                            raw_word_d   = raw_word_q;
                            data_out_d   = data_out_q;
                            data_valid_d = 1'b0;
                        end else begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge MASTER_CLK) begin
        if (RESET) begin
            state_q      <= ST_HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            raw_word_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sync_found_q <= 1'b0;
`ifdef MFM_ERRCHK_EN
            mfm_err_q    <= 1'b0;
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            raw_word_q   <= raw_word_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sync_found_q <= sync_found_d;
`ifdef MFM_ERRCHK_EN
            mfm_err_q    <= mfm_err_d;
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign bus.RAW_WORD   = raw_word_q;
    assign bus.DATA_OUT   = data_out_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.SYNC_FOUND = sync_found_q;
    assign bus.LOCKED     = (state_q == ST_LOCKED);
    assign bus.STATE_DBG  = state_q;
`ifdef MFM_ERRCHK_EN
    assign bus.MFM_ERR    = mfm_err_q;
`else
    assign bus.MFM_ERR    = 1'b0;
`endif

endmodule
